// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: memory-op codes, FSM states, alignment rule.
package mem_pkg;

    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    // size is memop[1:0]: 00 byte, 01 half, 10 word
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'b01:   return addr_lo[0];
            2'b10:   return |addr_lo;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/grant/rvalid bus between the MEM stage (master) and memory (slave).
interface mem_stage_if #(parameter int ADDR_W = 32);
    logic              req;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic              gnt;
    logic              rvalid;
    logic [31:0]       rdata;

    modport master (output req, wr, addr, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, wr, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/load_align.sv
// Picks the addressed byte/half/word out of a read word and sign- or zero-extends it.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  memop,
    output logic [31:0] result
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        result   = rdata;
        case (memop)
            MEMOP_B:  result = {{24{byte_sel[7]}}, byte_sel};
            MEMOP_BU: result = {24'h0, byte_sel};
            MEMOP_H:  result = {{16{half_sel[15]}}, half_sel};
            MEMOP_HU: result = {16'h0, half_sel};
            default:  result = rdata;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage with MEM/WB register: one instruction at a time, aligned loads/stores
// over a req/gnt/rvalid bus, misaligned accesses reported instead of issued.
//
//   state  | meaning
//   S_IDLE | ready for EX; ALU ops and misaligned accesses retire from here in one cycle
//   S_REQ  | dm.req held with fixed addr/be/wdata until dm.gnt
//   S_WAIT | load granted, waiting for dm.rvalid
module mem_stage
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int WREG_W = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [31:0]       ex_aluout,
    input  logic [31:0]       ex_wdata,
    input  logic [2:0]        ex_memop,
    input  logic              ex_memread,
    input  logic              ex_memwrite,
    input  logic              ex_memtoreg,
    input  logic              ex_regwrite,
    input  logic [WREG_W-1:0] ex_wreg,
    mem_stage_if.master       dm,
    output logic              wb_valid,
    output logic              wb_memtoreg,
    output logic [31:0]       wb_readdata,
    output logic [31:0]       wb_aluout,
    output logic              wb_regwrite,
    output logic [WREG_W-1:0] wb_wreg,
    output logic              addr_err
);
    state_t              state;
    logic                killed;
    logic [2:0]          memop_q;
    logic [31:0]         aluout_q;
    logic                memtoreg_q;
    logic                regwrite_q;
    logic [WREG_W-1:0]   wreg_q;

    logic                accept;
    logic                is_mem;
    logic                bad_align;
    logic                kill_now;
    logic [3:0]          st_be;
    logic [31:0]         st_data;
    logic [31:0]         ld_data;

    assign ex_ready  = (state == S_IDLE);
    assign accept    = ex_valid & ex_ready & ~flush;
    assign is_mem    = ex_memread | ex_memwrite;
    assign bad_align = misaligned(ex_memop[1:0], ex_aluout[1:0]);
    assign kill_now  = killed | flush;

    always_comb begin
        st_be   = 4'b1111;
        st_data = ex_wdata;
        case (ex_memop[1:0])
            2'b00: begin
                st_be   = 4'b0001 << ex_aluout[1:0];
                st_data = {4{ex_wdata[7:0]}};
            end
            2'b01: begin
                st_be   = ex_aluout[1] ? 4'b1100 : 4'b0011;
                st_data = {2{ex_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    load_align u_load_align (
        .rdata   (dm.rdata),
        .addr_lo (aluout_q[1:0]),
        .memop   (memop_q),
        .result  (ld_data)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            killed      <= 1'b0;
            memop_q     <= 3'b000;
            aluout_q    <= 32'h0;
            memtoreg_q  <= 1'b0;
            regwrite_q  <= 1'b0;
            wreg_q      <= '0;
            dm.req      <= 1'b0;
            dm.wr       <= 1'b0;
            dm.addr     <= '0;
            dm.be       <= 4'h0;
            dm.wdata    <= 32'h0;
            wb_valid    <= 1'b0;
            wb_memtoreg <= 1'b0;
            wb_readdata <= 32'h0;
            wb_aluout   <= 32'h0;
            wb_regwrite <= 1'b0;
            wb_wreg     <= '0;
            addr_err    <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            addr_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (!is_mem || bad_align) begin
                            wb_valid    <= 1'b1;
                            addr_err    <= is_mem;
                            wb_aluout   <= ex_aluout;
                            wb_memtoreg <= ex_memtoreg;
                            wb_regwrite <= ex_regwrite & ~is_mem;
                            wb_wreg     <= ex_wreg;
                        end else begin
                            state      <= S_REQ;
                            killed     <= 1'b0;
                            dm.req     <= 1'b1;
                            dm.wr      <= ex_memwrite;
                            dm.addr    <= {ex_aluout[ADDR_W-1:2], 2'b00};
                            dm.be      <= st_be;
                            dm.wdata   <= st_data;
                            memop_q    <= ex_memop;
                            aluout_q   <= ex_aluout;
                            memtoreg_q <= ex_memtoreg;
                            regwrite_q <= ex_regwrite;
                            wreg_q     <= ex_wreg;
                        end
                    end
                end
                S_REQ: begin
                    killed <= kill_now;
                    // a same-cycle rvalid cannot belong to this request; it is awaited in S_WAIT
                    if (dm.gnt) begin
                        dm.req <= 1'b0;
                        if (dm.wr) begin
                            state <= S_IDLE;
                            if (!kill_now) begin
                                wb_valid    <= 1'b1;
                                wb_aluout   <= aluout_q;
                                wb_memtoreg <= memtoreg_q;
                                wb_regwrite <= regwrite_q;
                                wb_wreg     <= wreg_q;
                            end
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    killed <= kill_now;
                    if (dm.rvalid) begin
                        state <= S_IDLE;
                        if (!kill_now) begin
                            wb_valid    <= 1'b1;
                            wb_readdata <= ld_data;
                            wb_aluout   <= aluout_q;
                            wb_memtoreg <= memtoreg_q;
                            wb_regwrite <= regwrite_q;
                            wb_wreg     <= wreg_q;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage: sequential driver, bus memory slave,
// and a per-cycle compare process against a queue of expected WB results.
module tb_mem_stage;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_aluout;
    logic [31:0] ex_wdata;
    logic [2:0]  ex_memop;
    logic        ex_memread;
    logic        ex_memwrite;
    logic        ex_memtoreg;
    logic        ex_regwrite;
    logic [4:0]  ex_wreg;
    logic        wb_valid;
    logic        wb_memtoreg;
    logic [31:0] wb_readdata;
    logic [31:0] wb_aluout;
    logic        wb_regwrite;
    logic [4:0]  wb_wreg;
    logic        addr_err;

    mem_stage_if #(.ADDR_W(32)) dm ();

    mem_stage #(.ADDR_W(32), .WREG_W(5)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .flush       (flush),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .ex_aluout   (ex_aluout),
        .ex_wdata    (ex_wdata),
        .ex_memop    (ex_memop),
        .ex_memread  (ex_memread),
        .ex_memwrite (ex_memwrite),
        .ex_memtoreg (ex_memtoreg),
        .ex_regwrite (ex_regwrite),
        .ex_wreg     (ex_wreg),
        .dm          (dm),
        .wb_valid    (wb_valid),
        .wb_memtoreg (wb_memtoreg),
        .wb_readdata (wb_readdata),
        .wb_aluout   (wb_aluout),
        .wb_regwrite (wb_regwrite),
        .wb_wreg     (wb_wreg),
        .addr_err    (addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] aluout;
        logic        memtoreg;
        logic        regwrite;
        logic [4:0]  wreg;
        logic        is_load;
        logic [31:0] rd;
        logic        err;
    } wb_item_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_item_t;

    wb_item_t    exp_q[$];
    bus_item_t   bus_q[$];
    logic [31:0] model_mem [256];
    logic [31:0] bus_mem [256];
    int          total = 0;
    int          bad = 0;
    int          txn_cnt = 0;
    int          force_gnt = -1;
    int          force_rd = -1;
    logic [31:0] last_gnt_addr = 32'h0;
    logic [31:0] last_gnt_wdata = 32'h0;
    logic [3:0]  last_gnt_be = 4'h0;
    logic        gnt_edge = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] op);
        case (op[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] addr,
                                               input logic [2:0] op);
        int          sz;
        logic [31:0] v;
        sz = size_of(op);
        v  = word >> (8 * (addr % 4));
        if (sz == 1) begin
            v = v & 32'hFF;
            if (!op[2] && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = v & 32'hFFFF;
            if (!op[2] && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    // memory slave: random grant delay, rvalid 1..3 cycles after the grant
    initial begin
        int          gnt_wait;
        int          rd_cnt;
        logic [31:0] rd_data;
        bus_item_t   b;
        gnt_wait  = -1;
        rd_cnt    = 0;
        rd_data   = 32'h0;
        dm.gnt    = 1'b0;
        dm.rvalid = 1'b0;
        dm.rdata  = 32'h0;
        forever begin
            @(negedge clk);
            dm.gnt    = 1'b0;
            dm.rvalid = 1'b0;
            if (!resetn) begin
                gnt_wait = -1;
                rd_cnt   = 0;
            end else begin
                if (rd_cnt > 0) begin
                    rd_cnt--;
                    if (rd_cnt == 0) begin
                        dm.rvalid = 1'b1;
                        dm.rdata  = rd_data;
                    end
                end
                if (dm.req) begin
                    if (gnt_wait < 0) gnt_wait = (force_gnt >= 0) ? force_gnt : int'($urandom_range(0, 3));
                    if (gnt_wait == 0) begin
                        dm.gnt   = 1'b1;
                        gnt_wait = -1;
                        txn_cnt++;
                        last_gnt_addr  = dm.addr;
                        last_gnt_be    = dm.be;
                        last_gnt_wdata = dm.wdata;
                        if (bus_q.size() == 0) begin
                            chk("bus_unexpected", 32'd1, 32'd0);
                        end else begin
                            b = bus_q.pop_front();
                            chk("bus_wr", 32'(dm.wr), 32'(b.wr));
                            chk("bus_addr", dm.addr, b.addr);
                            chk("bus_be", 32'(dm.be), 32'(b.be));
                            if (b.wr) chk("bus_wdata", dm.wdata, b.wdata);
                        end
                        if (dm.wr) begin
                            for (int i = 0; i < 4; i++)
                                if (dm.be[i]) bus_mem[dm.addr[9:2]][8*i +: 8] = dm.wdata[8*i +: 8];
                        end else begin
                            rd_data = bus_mem[dm.addr[9:2]];
                            rd_cnt  = (force_rd > 0) ? force_rd : int'($urandom_range(1, 3));
                        end
                    end else begin
                        gnt_wait--;
                    end
                end
            end
        end
    end

    always @(posedge clk) gnt_edge <= dm.gnt;

    // compare process: bus request stability and WB results every cycle
    initial begin
        logic        prev_req;
        logic [31:0] prev_addr;
        logic [31:0] prev_wdata;
        logic [3:0]  prev_be;
        logic        prev_wr;
        logic [31:0] last_rd;
        wb_item_t    it;
        prev_req   = 1'b0;
        prev_addr  = 32'h0;
        prev_wdata = 32'h0;
        prev_be    = 4'h0;
        prev_wr    = 1'b0;
        last_rd    = 32'h0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_req = 1'b0;
                last_rd  = 32'h0;
            end else begin
                if (prev_req && !gnt_edge) begin
                    chk("req_held", 32'(dm.req), 32'd1);
                    chk("req_addr_stable", dm.addr, prev_addr);
                    chk("req_be_stable", 32'(dm.be), 32'(prev_be));
                    chk("req_wdata_stable", dm.wdata, prev_wdata);
                    chk("req_wr_stable", 32'(dm.wr), 32'(prev_wr));
                end
                if (dm.req) begin
                    chk("ex_ready_busy", 32'(ex_ready), 32'd0);
                    chk("req_addr_aligned", 32'(dm.addr[1:0]), 32'd0);
                end
                if (wb_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("wb_unexpected", 32'd1, 32'd0);
                    end else begin
                        it = exp_q.pop_front();
                        if (it.is_load) last_rd = it.rd;
                        chk("wb_aluout", wb_aluout, it.aluout);
                        chk("wb_memtoreg", 32'(wb_memtoreg), 32'(it.memtoreg));
                        chk("wb_regwrite", 32'(wb_regwrite), 32'(it.regwrite));
                        chk("wb_wreg", 32'(wb_wreg), 32'(it.wreg));
                        chk("wb_readdata", wb_readdata, last_rd);
                        chk("addr_err", 32'(addr_err), 32'(it.err));
                    end
                end else begin
                    chk("addr_err_no_wb", 32'(addr_err), 32'd0);
                end
                prev_req   = dm.req;
                prev_addr  = dm.addr;
                prev_wdata = dm.wdata;
                prev_be    = dm.be;
                prev_wr    = dm.wr;
            end
        end
    end

    task automatic randomize_ex();
        ex_aluout   = $urandom;
        ex_wdata    = $urandom;
        ex_memop    = 3'($urandom);
        ex_memread  = 1'($urandom);
        ex_memwrite = 1'($urandom);
        ex_memtoreg = 1'($urandom);
        ex_regwrite = 1'($urandom);
        ex_wreg     = 5'($urandom);
    endtask

    // called at posedge+1 with the stage idle; returns once the instruction has retired
    task automatic issue(input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] op,
                         input bit rd, input bit wr, input bit m2r, input bit rw,
                         input logic [4:0] wreg, input int flush_at, input bit idle_flush);
        wb_item_t  it;
        bus_item_t b;
        int        t0;
        int        sz;
        int        busy;
        int        cyc;
        bit        mem;
        bit        mis;
        bit        flushed;
        t0      = txn_cnt;
        mem     = rd | wr;
        sz      = size_of(op);
        mis     = mem && ((addr % sz) != 0);
        busy    = 0;
        cyc     = 0;
        flushed = 0;
        ex_aluout = addr; ex_wdata = wdata; ex_memop = op; ex_memread = rd; ex_memwrite = wr;
        ex_memtoreg = m2r; ex_regwrite = rw; ex_wreg = wreg;
        if (idle_flush) begin
            ex_valid = 1'b1;
            flush    = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
            chk("flush_idle_ready", 32'(ex_ready), 32'd1);
        end
        it.aluout   = addr;
        it.memtoreg = m2r;
        it.regwrite = rw && !mis;
        it.wreg     = wreg;
        it.is_load  = rd && !mis;
        it.rd       = model_load(model_mem[addr[9:2]], addr, op);
        it.err      = mis;
        if (mem && !mis) begin
            b.wr    = wr;
            b.addr  = addr & 32'hFFFF_FFFC;
            b.be    = 4'(((1 << sz) - 1) << (addr % 4));
            b.wdata = (sz == 1) ? {4{wdata[7:0]}} : (sz == 2) ? {2{wdata[15:0]}} : wdata;
            bus_q.push_back(b);
            if (wr)
                for (int i = 0; i < sz; i++)
                    model_mem[addr[9:2]][8*((addr % 4) + i) +: 8] = wdata[8*i +: 8];
        end
        exp_q.push_back(it);
        ex_valid = 1'b1;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        randomize_ex();
        if (!mem || mis) begin
            chk("single_cycle_ready", 32'(ex_ready), 32'd1);
            @(negedge clk); #1;
            chk("single_cycle_latency", 32'(exp_q.size()), 32'd0);
            @(posedge clk); #1;
        end else begin
            chk("busy_after_accept", 32'(ex_ready), 32'd0);
            while (!(ex_ready && exp_q.size() == 0)) begin
                if (!ex_ready) busy++;
                if (flush_at > 0 && busy == flush_at && !flushed && !ex_ready) begin
                    flush   = 1'b1;
                    flushed = 1;
                    void'(exp_q.pop_back());
                end
                @(posedge clk); #1;
                flush = 1'b0;
                cyc++;
                if (cyc > 60) begin
                    chk("retire_timeout", 32'(cyc), 32'd0);
                    exp_q.delete();
                    break;
                end
            end
        end
        chk("bus_txn_count", 32'(txn_cnt - t0), (mem && !mis) ? 32'd1 : 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [2:0]  op;
        int          kind;
        logic [31:0] addr;
        resetn   = 1'b0;
        flush    = 1'b0;
        ex_valid = 1'b0;
        randomize_ex();
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            model_mem[i] = v;
            bus_mem[i]   = v;
        end
        model_mem[64] = 32'h80FF_0011;
        bus_mem[64]   = 32'h80FF_0011;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex_ready", 32'(ex_ready), 32'd1);
        chk("rst_dm_req", 32'(dm.req), 32'd0);
        chk("rst_dm_wr", 32'(dm.wr), 32'd0);
        chk("rst_dm_addr", dm.addr, 32'd0);
        chk("rst_dm_be", 32'(dm.be), 32'd0);
        chk("rst_dm_wdata", dm.wdata, 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_readdata", wb_readdata, 32'd0);
        chk("rst_wb_aluout", wb_aluout, 32'd0);
        chk("rst_wb_regwrite", 32'(wb_regwrite), 32'd0);
        chk("rst_wb_wreg", 32'(wb_wreg), 32'd0);
        chk("rst_addr_err", 32'(addr_err), 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // 1: ALU op
        issue(32'h1234_5678, 32'h0, MEMOP_W, 0, 0, 0, 1, 5'd5, 0, 0);
        chk("t1_aluout", wb_aluout, 32'h1234_5678);
        chk("t1_wreg", 32'(wb_wreg), 32'd5);

        // 2: LB / LBU at 0x103
        issue(32'h0000_0103, 32'h0, MEMOP_B, 1, 0, 1, 1, 5'd7, 0, 0);
        chk("t2_lb_data", wb_readdata, 32'hFFFF_FF80);
        chk("t2_addr", last_gnt_addr, 32'h0000_0100);
        chk("t2_be", 32'(last_gnt_be), 32'b1000);
        issue(32'h0000_0103, 32'h0, MEMOP_BU, 1, 0, 1, 1, 5'd8, 0, 0);
        chk("t2_lbu_data", wb_readdata, 32'h0000_0080);

        // 3: SH with a 3-cycle grant delay
        force_gnt = 3;
        issue(32'h0000_0202, 32'hAAAA_BEEF, MEMOP_H, 0, 1, 0, 0, 5'd0, 0, 0);
        force_gnt = -1;
        chk("t3_addr", last_gnt_addr, 32'h0000_0200);
        chk("t3_be", 32'(last_gnt_be), 32'b1100);
        chk("t3_wdata", last_gnt_wdata, 32'hBEEF_BEEF);

        // 4: misaligned LW
        issue(32'h0000_0006, 32'h0, MEMOP_W, 1, 0, 1, 1, 5'd9, 0, 0);
        chk("t4_regwrite", 32'(wb_regwrite), 32'd0);

        // 5: LW flushed while waiting for rvalid
        force_gnt = 0;
        force_rd  = 3;
        issue(32'h0000_0300, 32'h0, MEMOP_W, 1, 0, 1, 1, 5'd10, 2, 0);
        force_gnt = -1;
        force_rd  = -1;
        chk("t5_ready", 32'(ex_ready), 32'd1);

        // 6: reset while a request is outstanding
        force_gnt   = 20;
        ex_aluout   = 32'h0000_0300; ex_memop = MEMOP_W; ex_memread = 1'b1; ex_memwrite = 1'b0;
        ex_valid    = 1'b1;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        chk("t6_req_up", 32'(dm.req), 32'd1);
        repeat (2) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("t6_req_down", 32'(dm.req), 32'd0);
        chk("t6_addr", dm.addr, 32'd0);
        chk("t6_be", 32'(dm.be), 32'd0);
        chk("t6_wb_aluout", wb_aluout, 32'd0);
        chk("t6_ready", 32'(ex_ready), 32'd1);
        @(posedge clk); #1;
        resetn    = 1'b1;
        force_gnt = -1;
        @(posedge clk); #1;
        chk("t6_idle_after", 32'(ex_ready), 32'd1);
        issue(32'hCAFE_0001, 32'h0, MEMOP_B, 0, 0, 1, 1, 5'd3, 0, 0);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 9);
            addr = $urandom_range(0, 1023);
            if (kind < 3) begin
                issue($urandom, $urandom, 3'($urandom), 0, 0, 1'($urandom), 1'($urandom),
                      5'($urandom), 0, ($urandom_range(0, 7) == 0));
            end else begin
                case ($urandom_range(0, 4))
                    0: op = MEMOP_B;
                    1: op = MEMOP_H;
                    2: op = MEMOP_W;
                    3: op = MEMOP_BU;
                    default: op = MEMOP_HU;
                endcase
                if (kind >= 7 && op[2]) op[2] = 1'b0;
                if ($urandom_range(0, 9) < 7) addr = addr & ~32'(size_of(op) - 1);
                issue(addr, $urandom, op, kind < 7, kind >= 7, 1'($urandom), 1'($urandom),
                      5'($urandom), ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0,
                      ($urandom_range(0, 7) == 0));
            end
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
